// File: rtl/csa_top.sv
// -----------------------------------------------------------------------------
// csa_top -- front-end of the CSA descrambler path.
//
// Receives descriptor-prefixed 188-byte MPEG-TS packets as 32-bit words,
// stores each frame in one half of a two-frame ping-pong buffer and, once the
// whole frame has arrived and checked out, routes it by PID:
//   ECM PID  -> one address strobe, then 184 payload bytes on the ECM/DDR port
//   EMM PID  -> full 188-byte packet on emm_send, 184 payload bytes on emm_dout
//   other    -> 51 words on ts_dout, sof flagged on descriptor word 0
// PIDs are programmed through 4-byte bursts on the config port.
//
// Ports:
//   clk_main          system clock
//   rst               asynchronous active-high reset
//   ts_din/_en        frame word input (TS bytes big-endian) and valid
//   con_din/_en       config byte input and valid
//   ts_dout/_en       {sof, word} pass-through output and valid
//   ecm_addr_dout/_en {desc0[3:0], desc1} ECM storage address and strobe
//   ecm_ddr_dout/_en  ECM payload byte and valid
//   emm_dout/_en      {first, byte} EMM payload bytes and valid
//   emm_send/_en      {first, byte} full EMM packet bytes and valid
//   erro_flag         one-cycle error pulse (bad, dropped or CC-broken frame)
//
// Build option:
//   CSA_CC_CHECK_EN   when defined, checks the continuity counter of the last
//                     pass-through PID and pulses erro_flag on a gap.
// -----------------------------------------------------------------------------
module csa_top #(
    parameter int DESC_WORDS = 4,
    parameter int TS_WORDS   = 47
) (
    input  logic        clk_main,
    input  logic        rst,
    input  logic [31:0] ts_din,
    input  logic        ts_din_en,
    input  logic [7:0]  con_din,
    input  logic        con_din_en,
    output logic [32:0] ts_dout,
    output logic        ts_dout_en,
    output logic [35:0] ecm_addr_dout,
    output logic        ecm_addr_dout_en,
    output logic [7:0]  ecm_ddr_dout,
    output logic        ecm_ddr_dout_en,
    output logic [8:0]  emm_dout,
    output logic        emm_dout_en,
    output logic [8:0]  emm_send,
    output logic        emm_send_en,
    output logic        erro_flag
);

    localparam int FRAME_WORDS = DESC_WORDS + TS_WORDS;
    localparam int TS_BYTES    = TS_WORDS * 4;

    typedef enum logic {BYTE_ECM = 1'b0, BYTE_EMM = 1'b1} byte_mode_t;

    // ---------------- configuration ----------------
    logic [1:0]  cfg_cnt;
    logic [7:0]  cfg_cmd;
    logic [4:0]  cfg_pid_hi;
    logic [7:0]  cfg_pid_lo;
    logic [12:0] ecm_pid, emm_pid;
    logic        ecm_en, emm_en;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_main or posedge rst) begin
        if (rst) begin
            cfg_cnt    <= 2'd0;
            cfg_cmd    <= 8'd0;
            cfg_pid_hi <= 5'd0;
            cfg_pid_lo <= 8'd0;
            ecm_pid    <= 13'h1FFF;
            emm_pid    <= 13'h1FFF;
            ecm_en     <= 1'b0;
            emm_en     <= 1'b0;
        end else if (con_din_en) begin
            cfg_cnt <= cfg_cnt + 2'd1;
            case (cfg_cnt)
                2'd0: cfg_cmd    <= con_din;
                2'd1: cfg_pid_hi <= con_din[4:0];
                2'd2: cfg_pid_lo <= con_din;
                default: begin
                    if (cfg_cmd == 8'h01) begin
                        ecm_pid <= {cfg_pid_hi, cfg_pid_lo};
                        ecm_en  <= con_din[0];
                    end else if (cfg_cmd == 8'h02) begin
                        emm_pid <= {cfg_pid_hi, cfg_pid_lo};
                        emm_en  <= con_din[0];
                    end
                end
            endcase
        end else begin
            // A gap inside a burst throws the partial burst away.
            cfg_cnt <= 2'd0;
        end
    end

    // ---------------- frame input ----------------
    logic        in_frame, wr_half, sync_bad, over_long, no_room;
    logic [5:0]  wr_cnt;
    logic [12:0] pid_cap;
    logic [3:0]  cc_cap, d0_cap;
    logic [31:0] d1_cap;
    logic [1:0]  occ;                   // halves owned by an output engine

    logic frame_start, frame_end, room, free_half, cur_half, mem_we;
    logic [6:0] mem_waddr;

    assign frame_start = ts_din_en & ~in_frame;
    assign frame_end   = ~ts_din_en & in_frame;
    assign room        = ~&occ;
    assign free_half   = occ[0];
    assign cur_half    = frame_start ? free_half : wr_half;
    assign mem_we      = ts_din_en & (frame_start ? room
                                      : (~no_room & (wr_cnt < 6'(FRAME_WORDS))));
    assign mem_waddr   = {cur_half, frame_start ? 6'd0 : wr_cnt};

    always_ff @(posedge clk_main or posedge rst) begin
        if (rst) begin
            in_frame  <= 1'b0;
            wr_half   <= 1'b0;
            wr_cnt    <= 6'd0;
            sync_bad  <= 1'b0;
            over_long <= 1'b0;
            no_room   <= 1'b0;
            pid_cap   <= 13'd0;
            cc_cap    <= 4'd0;
            d0_cap    <= 4'd0;
            d1_cap    <= 32'd0;
        end else if (frame_start) begin
            in_frame  <= 1'b1;
            wr_half   <= free_half;
            no_room   <= ~room;
            wr_cnt    <= 6'd1;
            sync_bad  <= 1'b0;
            over_long <= 1'b0;
            d0_cap    <= ts_din[3:0];
        end else if (ts_din_en) begin
            // Words beyond a full frame are ignored until ts_din_en drops.
            if (wr_cnt == 6'(FRAME_WORDS)) begin
                over_long <= 1'b1;
            end else begin
                wr_cnt <= wr_cnt + 6'd1;
                if (wr_cnt == 6'd1)
                    d1_cap <= ts_din;
                if (wr_cnt == 6'(DESC_WORDS)) begin
                    sync_bad <= (ts_din[31:24] != 8'h47);
                    pid_cap  <= ts_din[20:8];
                    cc_cap   <= ts_din[3:0];
                end
            end
        end else begin
            in_frame <= 1'b0;
        end
    end

    // NOTE: the frame store has no reset; its contents are only read after
    // being written, and a reset would prevent RAM inference.
    logic [31:0] mem [0:127];
    always_ff @(posedge clk_main) begin
        if (mem_we)
            mem[mem_waddr] <= ts_din;
    end

    // ---------------- completion decision ----------------
    logic w_busy, b_busy, w_half, b_half;
    logic [5:0] w_idx;
    logic [7:0] b_idx;
    byte_mode_t b_mode;

    logic frame_ok, hit_ecm, hit_emm, word_start, byte_start, frame_err, cc_err;

    assign frame_ok   = frame_end & (wr_cnt == 6'(FRAME_WORDS)) & ~sync_bad
                        & ~over_long & ~no_room;
    assign hit_ecm    = ecm_en & (pid_cap == ecm_pid);
    assign hit_emm    = emm_en & (pid_cap == emm_pid);
    assign byte_start = frame_ok & (hit_ecm | hit_emm) & ~b_busy;
    assign word_start = frame_ok & ~(hit_ecm | hit_emm) & ~w_busy;
    // Bad frames and frames whose engine is busy are dropped here.
    assign frame_err  = frame_end & ~byte_start & ~word_start;

    // Read ports: on a start cycle the first element comes straight from the
    // half just completed so output begins without an extra cycle.
    logic [31:0] w_rdata, b_word;
    logic [7:0]  b_rdata, b_idx_rd;
    logic        b_half_rd;

    assign w_rdata   = mem[word_start ? {wr_half, 6'd0} : {w_half, w_idx}];
    assign b_half_rd = byte_start ? wr_half : b_half;
    assign b_idx_rd  = byte_start ? 8'd0 : b_idx;
    assign b_word    = mem[{b_half_rd, 6'(DESC_WORDS) + b_idx_rd[7:2]}];

    // NOTE: every path assigns b_rdata (default arm present), so no latch.
    always_comb begin
        case (b_idx_rd[1:0])
            2'd0:    b_rdata = b_word[31:24];
            2'd1:    b_rdata = b_word[23:16];
            2'd2:    b_rdata = b_word[15:8];
            default: b_rdata = b_word[7:0];
        endcase
    end

`ifdef CSA_CC_CHECK_EN
    logic [12:0] cc_pid;
    logic [3:0]  cc_last;
    logic        cc_valid;

    assign cc_err = word_start & cc_valid & (pid_cap == cc_pid)
                    & (cc_cap != cc_last + 4'd1);

    always_ff @(posedge clk_main or posedge rst) begin
        if (rst) begin
            cc_pid   <= 13'd0;
            cc_last  <= 4'd0;
            cc_valid <= 1'b0;
        end else if (word_start) begin
            cc_pid   <= pid_cap;
            cc_last  <= cc_cap;
            cc_valid <= 1'b1;
        end
    end
`else
    assign cc_err = 1'b0;
`endif

    // ---------------- output engines ----------------
    always_ff @(posedge clk_main or posedge rst) begin
        if (rst) begin
            occ              <= 2'b00;
            w_busy           <= 1'b0;
            w_half           <= 1'b0;
            w_idx            <= 6'd0;
            b_busy           <= 1'b0;
            b_half           <= 1'b0;
            b_idx            <= 8'd0;
            b_mode           <= BYTE_ECM;
            ts_dout          <= 33'd0;
            ts_dout_en       <= 1'b0;
            ecm_addr_dout    <= 36'd0;
            ecm_addr_dout_en <= 1'b0;
            ecm_ddr_dout     <= 8'd0;
            ecm_ddr_dout_en  <= 1'b0;
            emm_dout         <= 9'd0;
            emm_dout_en      <= 1'b0;
            emm_send         <= 9'd0;
            emm_send_en      <= 1'b0;
            erro_flag        <= 1'b0;
        end else begin
            ts_dout          <= 33'd0;
            ts_dout_en       <= 1'b0;
            ecm_addr_dout    <= 36'd0;
            ecm_addr_dout_en <= 1'b0;
            ecm_ddr_dout     <= 8'd0;
            ecm_ddr_dout_en  <= 1'b0;
            emm_dout         <= 9'd0;
            emm_dout_en      <= 1'b0;
            emm_send         <= 9'd0;
            emm_send_en      <= 1'b0;
            erro_flag        <= frame_err | cc_err;

            // Word engine: 51 contiguous words.
            if (w_busy) begin
                ts_dout    <= {1'b0, w_rdata};
                ts_dout_en <= 1'b1;
                if (w_idx == 6'(FRAME_WORDS - 1)) begin
                    w_busy      <= 1'b0;
                    occ[w_half] <= 1'b0;
                end else begin
                    w_idx <= w_idx + 6'd1;
                end
            end else if (word_start) begin
                ts_dout      <= {1'b1, w_rdata};
                ts_dout_en   <= 1'b1;
                w_busy       <= 1'b1;
                w_half       <= wr_half;
                w_idx        <= 6'd1;
                occ[wr_half] <= 1'b1;
            end

            // Byte engine: b_idx is the TS byte index (0..187) output next.
            if (b_busy) begin
                if (b_mode == BYTE_ECM) begin
                    ecm_ddr_dout    <= b_rdata;
                    ecm_ddr_dout_en <= 1'b1;
                end else begin
                    emm_send    <= {1'b0, b_rdata};
                    emm_send_en <= 1'b1;
                    if (b_idx >= 8'd4) begin
                        emm_dout    <= {b_idx == 8'd4, b_rdata};
                        emm_dout_en <= 1'b1;
                    end
                end
                if (b_idx == 8'(TS_BYTES - 1)) begin
                    b_busy      <= 1'b0;
                    occ[b_half] <= 1'b0;
                end else begin
                    b_idx <= b_idx + 8'd1;
                end
            end else if (byte_start) begin
                b_busy       <= 1'b1;
                b_half       <= wr_half;
                occ[wr_half] <= 1'b1;
                if (hit_ecm) begin
                    // ECM wins when both PIDs match; payload follows the strobe.
                    b_mode           <= BYTE_ECM;
                    ecm_addr_dout    <= {d0_cap, d1_cap};
                    ecm_addr_dout_en <= 1'b1;
                    b_idx            <= 8'd4;
                end else begin
                    b_mode      <= BYTE_EMM;
                    emm_send    <= {1'b1, b_rdata};
                    emm_send_en <= 1'b1;
                    b_idx       <= 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_csa_top.sv
module tb_csa_top;

    logic        clk_main = 1'b0;
    logic        rst;
    logic [31:0] ts_din;
    logic        ts_din_en;
    logic [7:0]  con_din;
    logic        con_din_en;
    logic [32:0] ts_dout;
    logic        ts_dout_en;
    logic [35:0] ecm_addr_dout;
    logic        ecm_addr_dout_en;
    logic [7:0]  ecm_ddr_dout;
    logic        ecm_ddr_dout_en;
    logic [8:0]  emm_dout;
    logic        emm_dout_en;
    logic [8:0]  emm_send;
    logic        emm_send_en;
    logic        erro_flag;

    csa_top dut (
        .clk_main        (clk_main),
        .rst             (rst),
        .ts_din          (ts_din),
        .ts_din_en       (ts_din_en),
        .con_din         (con_din),
        .con_din_en      (con_din_en),
        .ts_dout         (ts_dout),
        .ts_dout_en      (ts_dout_en),
        .ecm_addr_dout   (ecm_addr_dout),
        .ecm_addr_dout_en(ecm_addr_dout_en),
        .ecm_ddr_dout    (ecm_ddr_dout),
        .ecm_ddr_dout_en (ecm_ddr_dout_en),
        .emm_dout        (emm_dout),
        .emm_dout_en     (emm_dout_en),
        .emm_send        (emm_send),
        .emm_send_en     (emm_send_en),
        .erro_flag       (erro_flag)
    );

    always #5 clk_main = ~clk_main;

`ifdef CSA_CC_CHECK_EN
    localparam int CC_ERRS = 1;
`else
    localparam int CC_ERRS = 0;
`endif

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always @(posedge clk_main) cyc <= cyc + 1;

    // Output recorders: append only, the stimulus block reads them.
    logic [32:0] tsq[$];
    int          tscyc[$];
    logic [8:0]  sendq[$], emmq[$];
    int          sendcyc[$], emmcyc[$];
    logic [7:0]  ecmq[$];
    int          ecmcyc[$];
    logic [35:0] addrq[$];
    int          addrcyc[$];
    int          err_cnt = 0;

    always @(negedge clk_main) begin
        if (ts_dout_en)       begin tsq.push_back(ts_dout);         tscyc.push_back(cyc);   end
        if (emm_send_en)      begin sendq.push_back(emm_send);      sendcyc.push_back(cyc); end
        if (emm_dout_en)      begin emmq.push_back(emm_dout);       emmcyc.push_back(cyc);  end
        if (ecm_ddr_dout_en)  begin ecmq.push_back(ecm_ddr_dout);   ecmcyc.push_back(cyc);  end
        if (ecm_addr_dout_en) begin addrq.push_back(ecm_addr_dout); addrcyc.push_back(cyc); end
        if (erro_flag) err_cnt++;
    end

    int tb0, sb0, eb0, cb0, ab0, er0;
    int t_last;
    int tl[99];

    task automatic mark();
        tb0 = tsq.size();
        sb0 = sendq.size();
        eb0 = emmq.size();
        cb0 = ecmq.size();
        ab0 = addrq.size();
        er0 = err_cnt;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ts_byte(input logic [7:0] sync, input int cc, input int t);
        case (t)
            0:       return sync;
            1:       return 8'h40;
            2:       return 8'h01;
            3:       return {4'h0, 4'(cc)};
            default: return 8'(t - 3);
        endcase
    endfunction

    function automatic logic [31:0] frame_word(input int d0, input logic [7:0] sync,
                                               input int cc, input int j);
        int t0;
        case (j)
            0: return 32'(d0);
            1: return 32'h0000_0002;
            2: return 32'hC012_0802;
            3: return 32'h0000_4E20;
            default: begin
                if (j > 50) return 32'hDEAD_0000 | 32'(j);
                t0 = 4 * (j - 4);
                return {ts_byte(sync, cc, t0), ts_byte(sync, cc, t0 + 1),
                        ts_byte(sync, cc, t0 + 2), ts_byte(sync, cc, t0 + 3)};
            end
        endcase
    endfunction

    task automatic send_frame(input int d0, input logic [7:0] sync, input int cc,
                              input int nwords, input int gap);
        for (int j = 0; j < nwords; j++) begin
            @(posedge clk_main); #1;
            ts_din_en = 1'b1;
            ts_din    = frame_word(d0, sync, cc, j);
            t_last    = cyc;
        end
        for (int g = 0; g < gap; g++) begin
            @(posedge clk_main); #1;
            ts_din_en = 1'b0;
            ts_din    = 32'd0;
        end
    endtask

    task automatic send_cfg(input logic [31:0] bytes, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_main); #1;
            con_din_en = 1'b1;
            con_din    = bytes[31 - 8*k -: 8];
        end
        @(posedge clk_main); #1;
        con_din_en = 1'b0;
        con_din    = 8'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_main);
        #1;
    endtask

    initial begin
        int bad;
        int n0;
        logic [32:0] exp_w;
        logic [8:0]  exp_b;

        rst = 1'b1; ts_din = 32'd0; ts_din_en = 1'b0; con_din = 8'd0; con_din_en = 1'b0;
        idle(3);
        chk("rst_ts",  {ts_dout_en, ts_dout}, 64'd0);
        chk("rst_ecm", {ecm_addr_dout_en, ecm_addr_dout, ecm_ddr_dout_en, ecm_ddr_dout}, 64'd0);
        chk("rst_emm", {emm_dout_en, emm_dout, emm_send_en, emm_send, erro_flag}, 64'd0);
        rst = 1'b0;
        idle(2);

        // Unknown command must change nothing; then 99 pass-through frames.
        send_cfg(32'h0300_0101, 4);
        mark();
        for (int i = 0; i < 99; i++) begin
            send_frame(i, 8'h47, i, 51, 3);
            tl[i] = t_last;
        end
        idle(60);
        chk("pt_words", tsq.size() - tb0, 99 * 51);
        chk("pt_err",   err_cnt - er0, 0);
        chk("pt_emm",   sendq.size() - sb0, 0);
        for (int i = 0; i < 99; i++) begin
            bad = 0;
            for (int j = 0; j < 51; j++) begin
                exp_w = {j == 0, frame_word(i, 8'h47, i, j)};
                if (tsq[tb0 + 51*i + j] !== exp_w) bad++;
                if (tscyc[tb0 + 51*i + j] != tscyc[tb0 + 51*i] + j) bad++;
            end
            chk("pt_frame", bad, 0);
            chk("pt_latency", tscyc[tb0 + 51*i] - tl[i], 2);
        end

        // EMM routing.
        send_cfg(32'h0200_0101, 4);
        mark();
        send_frame(99, 8'h47, 3, 51, 200);
        chk("emm_send_cnt", sendq.size() - sb0, 188);
        chk("emm_dout_cnt", emmq.size() - eb0, 184);
        chk("emm_latency",  sendcyc[sb0] - t_last, 2);
        bad = 0;
        for (int t = 0; t < 188; t++) begin
            exp_b = {t == 0, ts_byte(8'h47, 3, t)};
            if (sendq[sb0 + t] !== exp_b) bad++;
            if (sendcyc[sb0 + t] != sendcyc[sb0] + t) bad++;
        end
        chk("emm_send_bytes", bad, 0);
        bad = 0;
        for (int k = 0; k < 184; k++) begin
            exp_b = {k == 0, 8'(k + 1)};
            if (emmq[eb0 + k] !== exp_b) bad++;
            if (emmcyc[eb0 + k] != sendcyc[sb0 + k + 4]) bad++;
        end
        chk("emm_dout_bytes", bad, 0);
        chk("emm_no_ts",  tsq.size() - tb0, 0);
        chk("emm_no_ecm", ecmq.size() - cb0, 0);
        chk("emm_err",    err_cnt - er0, 0);

        // ECM routing with EMM also matching: ECM has priority.
        send_cfg(32'h0100_0101, 4);
        mark();
        send_frame(16, 8'h47, 5, 51, 200);
        chk("ecm_addr_cnt", addrq.size() - ab0, 1);
        chk("ecm_addr",     addrq[ab0], 36'h0_0000_0002);
        chk("ecm_latency",  addrcyc[ab0] - t_last, 2);
        chk("ecm_byte_cnt", ecmq.size() - cb0, 184);
        bad = 0;
        for (int k = 0; k < 184; k++) begin
            if (ecmq[cb0 + k] !== 8'(k + 1)) bad++;
            if (ecmcyc[cb0 + k] != addrcyc[ab0] + 1 + k) bad++;
        end
        chk("ecm_bytes",  bad, 0);
        chk("ecm_no_emm", (sendq.size() - sb0) + (emmq.size() - eb0), 0);
        chk("ecm_no_ts",  tsq.size() - tb0, 0);

        // Malformed frames: bad sync, truncated, overlong.
        mark();
        send_frame(20, 8'h46, 0, 51, 10);
        chk("badsync_err", err_cnt - er0, 1);
        mark();
        send_frame(21, 8'h47, 0, 30, 10);
        chk("short_err", err_cnt - er0, 1);
        mark();
        send_frame(22, 8'h47, 0, 53, 10);
        chk("long_err", err_cnt - er0, 1);
        chk("malformed_out", (tsq.size() - tb0) + (addrq.size() - ab0) + (sendq.size() - sb0), 0);

        // Broken burst is discarded, then ECM disabled: EMM back-to-back frames.
        send_cfg(32'h0200_0100, 3);
        send_cfg(32'h0100_0100, 4);
        mark();
        send_frame(5, 8'h47, 0, 51, 7);
        send_frame(6, 8'h47, 1, 51, 250);
        chk("b2b_send_cnt", sendq.size() - sb0, 188);
        chk("b2b_dout_cnt", emmq.size() - eb0, 184);
        chk("b2b_first",    sendq[sb0], 9'h147);
        chk("b2b_err",      err_cnt - er0, 1);
        chk("b2b_no_ecm",   addrq.size() - ab0, 0);

        // Continuity counter gap on pass-through (4 -> 6).
        send_cfg(32'h0200_0100, 4);
        mark();
        send_frame(30, 8'h47, 3, 51, 3);
        send_frame(31, 8'h47, 4, 51, 3);
        send_frame(32, 8'h47, 6, 51, 60);
        chk("cc_words", tsq.size() - tb0, 153);
        chk("cc_err",   err_cnt - er0, CC_ERRS);
        chk("cc_third", tsq[tb0 + 102], {1'b1, 32'd32});

        // Reset during output aborts it at once.
        mark();
        send_frame(40, 8'h47, 0, 51, 10);
        n0 = tsq.size();
        chk("mid_started", n0 - tb0, 8);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ts", {ts_dout_en, ts_dout}, 64'd0);
        @(posedge clk_main); #1;
        rst = 1'b0;
        idle(70);
        chk("mid_no_more", tsq.size() - n0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/csa_top.md
Name: csa_top

Overview:
- Front-end of the CSA descrambler path.
- Accepts descriptor-prefixed 188-byte MPEG-TS packets as 32-bit words and classifies each packet by PID, using PIDs programmed over a byte-wide config port.
- ECM packets go to the ECM/DDR interface, EMM packets to two byte streams, all other packets pass through unchanged on ts_dout.
- Malformed or dropped frames pulse erro_flag.

Parameters:
- DESC_WORDS, 4, descriptor words preceding each TS packet
- TS_WORDS, 47, TS packet words (188 bytes)

Ports:
- clk_main  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- ts_din  in  32  frame word; TS bytes big-endian, first byte in [31:24]
- ts_din_en  in  1  word valid; high for each frame word
- con_din  in  8  config byte
- con_din_en  in  1  config byte valid
- ts_dout  out  33  {sof, word}; sof=1 on descriptor word 0
- ts_dout_en  out  1  ts_dout valid
- ecm_addr_dout  out  36  {desc0[3:0], desc1[31:0]} ECM storage address
- ecm_addr_dout_en  out  1  one-cycle address strobe
- ecm_ddr_dout  out  8  ECM payload byte
- ecm_ddr_dout_en  out  1  ECM byte valid
- emm_dout  out  9  {first, byte}; EMM payload bytes (184)
- emm_dout_en  out  1  emm_dout valid
- emm_send  out  9  {first, byte}; full EMM TS packet (188 bytes) for forwarding
- emm_send_en  out  1  emm_send valid
- erro_flag  out  1  one-cycle error pulse

Behaviour:
Reset:
- All outputs 0.
- ecm_pid = emm_pid = 0x1FFF, both disabled.
- Buffers empty; config byte counter 0.

Config:
- con_din_en bursts of 4 bytes: cmd, {3'b0, pid[12:8]}, pid[7:0], flags (bit0 = enable).
- cmd 0x01 writes ecm_pid/ecm_en; cmd 0x02 writes emm_pid/emm_en; other cmd values are ignored.
- A con_din_en low mid-burst resets the byte counter and discards the burst.

Framing:
- A frame is 51 consecutive ts_din_en-high words: descriptor words 0–3, then TS words 4–50.
- Word 4 [31:24] must be 0x47. PID = word4[20:8].
- Error, frame discarded, erro_flag pulsed once at frame end, in any of these cases:
  - ts_din_en falls before 51 words
  - the sync byte is wrong
  - the frame is longer than 51 words (discard and resync at the next ts_din_en rising edge)
- Frames are written into a 2-frame ping-pong buffer (2x64x32).
- A frame is released only after all 51 words are received and checked.

Routing of a completed good frame:
- PID == ecm_pid && ecm_en:
  - ecm_addr_dout_en strobes once.
  - Next, the 184 payload bytes (TS bytes 4–187) appear on ecm_ddr_dout, 1 byte/cycle, contiguous.
- PID == emm_pid && emm_en:
  - emm_send outputs 188 TS bytes. In the same cycles, emm_dout outputs bytes 4–187, aligned so emm_dout byte k accompanies emm_send byte k+4.
  - bit8 = 1 on the first byte of each stream.
- Both match: ECM takes priority.
- Otherwise: ts_dout outputs all 51 words contiguously, sof on word 0.
- Latency: first output cycle is 2 clocks after the last input word.

Concurrency:
- The word output and the single byte serializer operate independently.
- A frame needing the byte serializer while it is busy, or arriving while both ping-pong halves are occupied, is dropped with an erro_flag pulse.

Reset mid-operation:
- Aborts all outputs immediately. Buffered frames are lost.

Optional Feature:
CSA_CC_CHECK_EN:
- Defined: track the 4-bit continuity counter (word4[3:0]) of the last pass-through PID.
- A good frame with the same PID whose CC != (previous+1) mod 16 pulses erro_flag; the frame is still forwarded.
- A PID change re-seeds the tracker without error.
- Not defined: no CC tracking.

Test Plan:
- Reset, no config; send 99 frames with desc0=i, desc1=0x2, desc2=0xC0120802, desc3=0x4E20, word4=0x474001_0X (CC=i[3:0]), payload bytes 1..184 → each frame appears on ts_dout as 51 words, sof on word 0, 2 clocks after input end, erro_flag never set.
- Config cmd 0x02, PID 0x0001, enable; send one frame → emm_send gives 188 bytes 47,40,01,0X,01..B8 with bit8 on the first; emm_dout gives 01..B8; nothing on ts_dout.
- Config cmd 0x01, PID 0x0001 (EMM also set) → ecm_addr_dout = 0x0_0000_0002 with desc0[3:0]=0 for i=16; then 184 bytes 01..B8 on ecm_ddr_dout; no EMM output.
- Frame with word4[31:24]=0x46, or ts_din_en dropped after 30 words → one erro_flag pulse, no outputs.
- Two EMM frames back-to-back with a 7-cycle gap → first is output, second is dropped with erro_flag.
- Under CSA_CC_CHECK_EN, skip one CC value → erro_flag pulse; the frame still appears on ts_dout.
